// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - MulDivWidth : default operand width (HI and LO are this wide each)
//   - op_e        : decode opcodes presented on muldiv_seq.op
//   - state_e     : sequencer FSM states
//   - step_mode_e : selects add-shift (multiply) or subtract-shift (divide) iteration
package muldiv_pkg;

  localparam int unsigned MulDivWidth = 32;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMfhi  = 3'd4,
    OpMflo  = 3'd5,
    OpMthi  = 3'd6,
    OpMtlo  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } state_e;

  typedef enum logic {
    StepMul,
    StepDiv
  } step_mode_e;

  // Signed variants work on magnitudes and fix the sign up afterwards.
  function automatic logic op_is_signed(op_e op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

  function automatic logic op_is_div(op_e op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the sequential multiplier/divider.
//   mode   in  StepMul: shift-add on {hi, lo}, lo holds the multiplier (LSB first)
//              StepDiv: restoring step on {hi=remainder, lo=dividend/quotient}
//   hi     in  upper accumulator half (partial product / partial remainder)
//   lo     in  lower accumulator half (multiplier bits / dividend-quotient bits)
//   opnd   in  multiplicand (mul) or divisor (div) magnitude
//   hi_nxt out upper half after this iteration
//   lo_nxt out lower half after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MulDivWidth
) (
  input  step_mode_e       mode,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier bit is set, keep
    // the carry, then shift the whole 2*WIDTH accumulator right by one.
    sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    shifted = {hi, lo[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd};
    // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
    diff    = shifted[WIDTH-1:0] - opnd;

    if (mode == StepDiv) begin
      hi_nxt = ge ? diff : shifted[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ge};
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle HI/LO multiply/divide sequencer beside the ALU.
// Owns HI/LO, runs MULT/MULTU as shift-add and DIV/DIVU as restoring division
// (WIDTH iterations plus one sign-fix cycle), and stalls decode while busy.
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   op_valid in   decode presents a muldiv-class instruction
//   op       in   opcode (op_e)
//   rs_val   in   operand A: dividend/multiplicand, MTHI/MTLO source
//   rt_val   in   operand B: divisor/multiplier
//   flush    in   abort in-flight operation, HI/LO untouched
//   stall    out  op_valid while busy; requester must hold the op
//   busy     out  sequencer not idle
//   done     out  one-cycle pulse the cycle after MULT/DIV writes HI/LO
//   rd_data  out  HI for MFHI, LO for MFLO when accepted this cycle, else 0
//   hi, lo   out  architectural HI/LO registers
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MulDivWidth,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] a_raw_q;   // original dividend, returned in HI on divide by zero
  logic             neg_res_q; // product / quotient must be negated in FIX
  logic             neg_rem_q; // remainder takes the dividend's sign
  logic             is_div_q;
  logic             done_q;

  op_e              op_dec;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  step_mode_e       step_mode;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign op_dec = op_e'(op);

  // Operand conditioning at accept: magnitudes for signed ops, raw otherwise.
  always_comb begin
    a_neg = op_is_signed(op_dec) & rs_val[WIDTH-1];
    b_neg = op_is_signed(op_dec) & rt_val[WIDTH-1];
    a_mag = a_neg ? -rs_val : rs_val;
    b_mag = b_neg ? -rt_val : rt_val;
  end

  assign step_mode = (state_q == StDiv) ? StepDiv : StepMul;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode   (step_mode),
    .hi     (acc_hi_q),
    .lo     (acc_lo_q),
    .opnd   (opnd_q),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  // Sign fix-up and divide-by-zero override applied in the FIX cycle.
  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_res_q ? -prod : prod;
    quo_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
    if (!is_div_q) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (opnd_q == '0) begin
      fix_hi = a_raw_q;
      fix_lo = '1;
    end else begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        // Drops whatever is in flight (or being presented) without touching HI/LO.
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (op_valid) begin
              unique case (op_dec)
                OpMult, OpMultu, OpDiv, OpDivu: begin
                  acc_hi_q  <= '0;
                  a_raw_q   <= rs_val;
                  neg_res_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  is_div_q  <= op_is_div(op_dec);
                  cnt_q     <= CNT_W'(WIDTH - 1);
                  if (op_is_div(op_dec)) begin
                    acc_lo_q <= a_mag;
                    opnd_q   <= b_mag;
                    state_q  <= StDiv;
                  end else begin
                    acc_lo_q <= b_mag;
                    opnd_q   <= a_mag;
                    state_q  <= StMul;
                  end
                end
                OpMthi: hi_q <= rs_val;
                OpMtlo: lo_q <= rs_val;
                default: ; // MFHI/MFLO are served combinationally
              endcase
            end
          end
          StMul, StDiv: begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            if (cnt_q == '0) begin
              state_q <= StFix;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          StFix: begin
            hi_q    <= fix_hi;
            lo_q    <= fix_lo;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy  = (state_q != StIdle);
  assign stall = op_valid & busy;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    rd_data = '0;
    if (op_valid && !stall) begin
      if (op_dec == OpMfhi) begin
        rd_data = hi_q;
      end else if (op_dec == OpMflo) begin
        rd_data = lo_q;
      end
    end
  end

endmodule
